// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: EXE-stage multiply/divide sequencer with pipeline stall request and held result
module mul_div_ctrl #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [5:0]  stall,
    input  logic [3:0]  mul_div_op,
    input  logic        mul_div_sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stallreq,
    output logic [31:0] mul_div_result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        sign_q, sign_d;
    logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, res_q, res_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_enc;
    logic [31:0] a_mag, b_mag, q_n, r_n, q_fix, r_fix;
    logic [32:0] trial, diff;
    logic [63:0] prod;
    logic        unused;

    assign unused = ^{stall[5:4], stall[2:0]};
    assign op_enc = mul_div_op[0] ? 2'd0 : mul_div_op[1] ? 2'd1 : mul_div_op[2] ? 2'd2 : 2'd3;
    assign a_mag  = mul_div_sign & a[31] ? -a : a;
    assign b_mag  = sign_q & b_q[31] ? -b_q : b_q;
    // Sign-extending to 64 bits lets one multiplier serve signed and unsigned
    assign prod   = {{32{sign_q & a_q[31]}}, a_q} * {{32{sign_q & b_q[31]}}, b_q};
    assign trial  = {rem_q, quo_q[31]};
    assign diff   = trial - {1'b0, b_mag};
    assign r_n    = diff[32] ? trial[31:0] : diff[31:0];
    assign q_n    = {quo_q[30:0], ~diff[32]};
    assign q_fix  = sign_q & (a_q[31] ^ b_q[31]) ? -q_n : q_n;
    assign r_fix  = sign_q & a_q[31] ? -r_n : r_n;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sign_d  = sign_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|mul_div_op) begin
                a_d     = a;
                b_d     = b;
                sel_d   = op_enc[0];
                sign_d  = mul_div_sign;
                quo_d   = a_mag;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = op_enc[1] ? DIV : MUL;
            end
            MUL: begin
                res_d   = sel_q ? prod[63:32] : prod[31:0];
                state_d = DONE;
            end
            DIV: if (b_q == '0) begin
                res_d   = sel_q ? a_q : '1;
                state_d = DONE;
            end else begin
                rem_d = r_n;
                quo_d = q_n;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(DIV_ITER - 1)) begin
                    res_d   = sel_q ? r_fix : q_fix;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = stall[3] ? DONE : IDLE;
        endcase
        // Flush wins over everything, including a new op arriving in IDLE
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            sign_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sign_q  <= sign_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stallreq       = ~flush & ~reset & ((state_q == IDLE & |mul_div_op) | state_q == MUL | state_q == DIV);
    assign busy           = state_q == MUL | state_q == DIV;
    assign mul_div_result = res_q;
endmodule

// File: tb/tb_mul_div_ctrl.sv
// tb_mul_div_ctrl: randomized scoreboard bench for mul_div_ctrl against an arithmetic reference model
module tb_mul_div_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [5:0]  stall = '0;
    logic [3:0]  mul_div_op = '0;
    logic        mul_div_sign = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        stallreq, busy;
    logic [31:0] mul_div_result;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int   checks = 0, errors = 0;

    mul_div_ctrl #(.DIV_ITER(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall), .mul_div_op(mul_div_op),
        .mul_div_sign(mul_div_sign), .a(a), .b(b), .stallreq(stallreq),
        .mul_div_result(mul_div_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic s, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        if (op[0]) return p[31:0];
        if (op[1]) return p[63:32];
        if (y == 32'd0) return op[2] ? 32'hFFFF_FFFF : x;
        q = sx / sy;
        r = sx % sy;
        return op[2] ? q[31:0] : r[31:0];
    endfunction

    // Issues one op, holds it in EXE until the result appears, then holds DONE for `hold` cycles
    task automatic run_op(input logic [3:0] op, input logic sgn, input logic [31:0] av, input logic [31:0] bv, input int hold);
        exp_t e;
        int   n;
        e.res = model(op, sgn, av, bv);
        e.lat = (op[0] | op[1] | bv == 32'd0) ? 2 : 33;
        sb.push_back(e);
        mul_div_op = op; mul_div_sign = sgn; a = av; b = bv; stall = 6'b001000;
        @(posedge clk); #1;
        a = $urandom; b = $urandom; mul_div_sign = $urandom_range(0, 1);
        n = 0;
        while (stallreq && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL timeout: stallreq still %b after %0d cycles, required 0", stallreq, n);
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        stall = '0; mul_div_op = '0;
        @(posedge clk); #1;
    endtask

    // Monitor: counts stall cycles per op and compares each delivered result against the scoreboard
    int          run = 0;
    logic        holding = 1'b0, post_flush = 1'b0;
    logic [31:0] held = '0;
    always @(negedge clk) begin
        if (reset) begin
            run = 0; holding = 1'b0; post_flush = 1'b0;
        end else if (flush) begin
            chk("flush_stallreq", 32'(stallreq), 32'd0);
            run = 0; holding = 1'b0; post_flush = 1'b1;
        end else begin
            if (post_flush) begin
                chk("flush_idle_busy", 32'(busy), 32'd0);
                post_flush = 1'b0;
            end
            if (stallreq) begin
                run++;
                holding = 1'b0;
            end else if (run > 0) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: result %h with empty scoreboard", mul_div_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", mul_div_result, e.res);
                    chk("latency", 32'(run), 32'(e.lat));
                    chk("done_busy", 32'(busy), 32'd0);
                end
                held = mul_div_result; holding = 1'b1; run = 0;
            end else if (holding) begin
                chk("hold_result", mul_div_result, held);
            end
        end
    end

    initial begin
        mul_div_op = 4'b0001;
        @(negedge clk);
        chk("reset_stallreq", 32'(stallreq), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", mul_div_result, 32'd0);
        @(posedge clk); #1;
        mul_div_op = '0; reset = 1'b0;
        @(posedge clk); #1;
        run_op(4'b0001, 1'b1, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(4'b0010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(4'b0100, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(4'b1000, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(4'b0100, 1'b0, 32'd5, 32'd0, 0);
        run_op(4'b1000, 1'b0, 32'd5, 32'd0, 0);
        run_op(4'b0100, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(4'b1000, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        // Flush in the middle of a divide
        mul_div_op = 4'b0100; mul_div_sign = 1'b0; a = 32'd1000; b = 32'd3; stall = 6'b001000;
        repeat (11) begin
            @(posedge clk); #1;
        end
        flush = 1'b1; mul_div_op = '0; stall = '0;
        @(posedge clk); #1;
        flush = 1'b0;
        run_op(4'b0100, 1'b0, 32'd100, 32'd7, 4);
        // Flush coinciding with a new op in IDLE must latch nothing
        mul_div_op = 4'b0001; a = 32'd9; b = 32'd9; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; mul_div_op = '0;
        @(posedge clk); #1;
        // Reset in the middle of a divide clears the result
        mul_div_op = 4'b1000; a = 32'd50; b = 32'd3; stall = 6'b001000;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; mul_div_op = '0; stall = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_result", mul_div_result, 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_stallreq", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            op = 4'($urandom_range(1, 15));
            x  = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            run_op(op, 1'($urandom_range(0, 1)), x, y, $urandom_range(0, 3));
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
